// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the bus arbiter: FSM state encoding, the master
// count ceiling and the watchdog counter width.
package bus_arbiter_pkg;

  localparam int MAX_MASTERS = 8;
  localparam int WDOG_WIDTH  = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANTED = 2'd1,
    BUSY    = 2'd2,
    ABORT   = 2'd3
  } arbState_e;

endpackage

// File: rtl/bus_arbiter_rr_picker.sv
// Round-robin picker: finds the first requesting master strictly after
// lastGranted, wrapping from nrOfMasters-1 back to 0. Purely combinational.
module rr_picker import bus_arbiter_pkg::*; #(
  parameter int nrOfMasters = 4
) (
  input  logic [nrOfMasters-1:0] requests,
  input  logic [2:0]             lastGranted,
  output logic [nrOfMasters-1:0] oneHot,
  output logic [2:0]             index,
  output logic                   anyRequest
);

  if (nrOfMasters < 2 || nrOfMasters > MAX_MASTERS) begin : gBadMasterCount
    $error("rr_picker: nrOfMasters must be 2..8");
  end

  // Walk offsets 1..N after lastGranted; the first requester seen wins.
  always_comb begin
    int target;
    oneHot     = '0;
    index      = '0;
    anyRequest = 1'b0;
    target     = 0;
    for (int off = 1; off <= nrOfMasters; off++) begin
      target = (int'(lastGranted) + off) % nrOfMasters;
      for (int i = 0; i < nrOfMasters; i++) begin
        if (!anyRequest && i == target && requests[i]) begin
          anyRequest = 1'b1;
          oneHot[i]  = 1'b1;
          index      = 3'(i);
        end
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin shared-bus arbiter with IDLE/GRANTED/BUSY/ABORT FSM.
// Optional watchdog compiled in with `define BUS_ARB_WATCHDOG_EN: a stuck
// transaction is aborted after timeoutCycles with one-cycle end and error
// strobes. Without it the strobes are tied low and ABORT is unreachable.
//
// Handshake: a master holds its requestsIn bit from request until its
// transaction ends. Once granted it pulses beginTransactionIn; the slave
// pulses endTransactionIn to finish. Dropping the request while GRANTED
// (no begin) releases the grant without advancing the round-robin pointer.
module bus_arbiter import bus_arbiter_pkg::*; #(
  parameter int nrOfMasters   = 4,
  parameter int timeoutCycles = 255
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [nrOfMasters-1:0] requestsIn,
  input  logic                   beginTransactionIn,
  input  logic                   endTransactionIn,
  output logic [nrOfMasters-1:0] grantsOut,
  output logic [2:0]             grantIndexOut,
  output logic                   busIdleOut,
  output logic                   endTransactionOut,
  output logic                   busErrorOut,
  output arbState_e              debugState
);

  if (timeoutCycles < 1 || timeoutCycles > 65535) begin : gBadTimeout
    $error("bus_arbiter: timeoutCycles must be 1..65535");
  end

  arbState_e              state, nextState;
  logic [nrOfMasters-1:0] nextGrants, pickOneHot;
  logic [2:0]             nextIndex, pickIndex, lastGranted, nextLast;
  logic                   pickAny, holding, timeoutHit;

  rr_picker #(.nrOfMasters(nrOfMasters)) picker (
    .requests    (requestsIn),
    .lastGranted (lastGranted),
    .oneHot      (pickOneHot),
    .index       (pickIndex),
    .anyRequest  (pickAny)
  );

  // The granted master is still asking for the bus.
  assign holding    = |(requestsIn & grantsOut);
  assign busIdleOut = (state == IDLE);
  assign debugState = state;

  // Next-state and next-grant decode; a clean release beats a timeout.
  always_comb begin
    nextState  = state;
    nextGrants = grantsOut;
    nextIndex  = grantIndexOut;
    nextLast   = lastGranted;
    case (state)
      IDLE: begin
        if (pickAny) begin
          nextState  = GRANTED;
          nextGrants = pickOneHot;
          nextIndex  = pickIndex;
        end
      end
      GRANTED: begin
        if (!beginTransactionIn && !holding) begin
          nextState  = IDLE;
          nextGrants = '0;
          nextIndex  = '0;
        end else if (timeoutHit) begin
          nextState  = ABORT;
          nextGrants = '0;
          nextIndex  = '0;
          nextLast   = grantIndexOut;
        end else if (beginTransactionIn) begin
          nextState  = BUSY;
        end
      end
      BUSY: begin
        if (endTransactionIn || timeoutHit) begin
          nextState  = endTransactionIn ? IDLE : ABORT;
          nextGrants = '0;
          nextIndex  = '0;
          nextLast   = grantIndexOut;
        end
      end
      ABORT:   nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // State, grant and round-robin pointer registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      grantsOut     <= '0;
      grantIndexOut <= '0;
      lastGranted   <= 3'(nrOfMasters - 1);
    end else begin
      state         <= nextState;
      grantsOut     <= nextGrants;
      grantIndexOut <= nextIndex;
      lastGranted   <= nextLast;
    end
  end

`ifdef BUS_ARB_WATCHDOG_EN
  localparam logic [WDOG_WIDTH-1:0] LAST_COUNT = WDOG_WIDTH'(timeoutCycles - 1);

  logic [WDOG_WIDTH-1:0] wdogCount;
  logic                  inTransaction;

  assign inTransaction = (state == GRANTED) || (state == BUSY);
  // Count reaching timeoutCycles happens on the edge that enters ABORT.
  assign timeoutHit    = inTransaction && (wdogCount == LAST_COUNT);

  // Watchdog: zero while idle so it starts at 0 on entering GRANTED.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wdogCount <= '0;
    end else if (state == IDLE) begin
      wdogCount <= '0;
    end else if (inTransaction) begin
      wdogCount <= wdogCount + WDOG_WIDTH'(1);
    end
  end

  assign endTransactionOut = (state == ABORT);
  assign busErrorOut       = (state == ABORT);
`else
  assign timeoutHit        = 1'b0;
  assign endTransactionOut = 1'b0;
  assign busErrorOut       = 1'b0;
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter (4 masters). Builds with or without
// BUS_ARB_WATCHDOG_EN; the watchdog build uses timeoutCycles = 10.
module tb_bus_arbiter;
  import bus_arbiter_pkg::*;

  localparam int N = 4;
`ifdef BUS_ARB_WATCHDOG_EN
  localparam int TMO = 10;
`else
  localparam int TMO = 255;
`endif

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    requestsIn = '0;
  logic            beginTransactionIn = 1'b0;
  logic            endTransactionIn = 1'b0;
  logic [N-1:0]    grantsOut;
  logic [2:0]      grantIndexOut;
  logic            busIdleOut, endTransactionOut, busErrorOut;
  arbState_e       debugState;

  int vectorsApplied = 0;
  int miscompares = 0;
  logic [9:0] exp_q[$];

  typedef struct {
    logic [N-1:0] req;
    logic         beg;
    logic         endt;
    logic [N-1:0] grant;
    logic [2:0]   idx;
    logic         idle;
  } vec_t;

  vec_t vecs[20];

  bus_arbiter #(.nrOfMasters(N), .timeoutCycles(TMO)) dut (
    .clock              (clock),
    .reset              (reset),
    .requestsIn         (requestsIn),
    .beginTransactionIn (beginTransactionIn),
    .endTransactionIn   (endTransactionIn),
    .grantsOut          (grantsOut),
    .grantIndexOut      (grantIndexOut),
    .busIdleOut         (busIdleOut),
    .endTransactionOut  (endTransactionOut),
    .busErrorOut        (busErrorOut),
    .debugState         (debugState)
  );

  // Clock and run-time bound
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, want finish before 200000");
    $fatal(1, "bench time limit");
  end

  // Helpers
  function automatic logic [9:0] observed();
    return {grantsOut, grantIndexOut, busIdleOut, endTransactionOut, busErrorOut};
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] want);
    vectorsApplied++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h", name, act, want);
    end
  endtask

  task automatic push_exp(input logic [N-1:0] g, input logic [2:0] i, input logic idle,
                          input logic eo, input logic err);
    exp_q.push_back({g, i, idle, eo, err});
  endtask

  task automatic pop_compare(input string name);
    if (exp_q.size() == 0) begin
      vectorsApplied++;
      miscompares++;
      $display("FAIL %s: got empty queue, want an expected entry", name);
    end else begin
      check(name, 16'(observed()), 16'(exp_q.pop_front()));
    end
  endtask

  // Driver tasks
  task automatic drive(input logic [N-1:0] r, input logic b, input logic e);
    requestsIn = r;
    beginTransactionIn = b;
    endTransactionIn = e;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive('0, 1'b0, 1'b0);
    repeat (2) @(posedge clock);
    #1;
    check("reset_outputs", 16'(observed()), 16'({4'b0000, 3'd0, 1'b1, 1'b0, 1'b0}));
    check("reset_state", 16'(debugState), 16'(IDLE));
    reset = 1'b0;
  endtask

  initial begin
    vecs = '{
      '{4'b0110, 1'b0, 1'b0, 4'b0010, 3'd1, 1'b0},  // first grant after reset: master 1
      '{4'b0000, 1'b0, 1'b0, 4'b0000, 3'd0, 1'b1},  // drop before begin
      '{4'b0100, 1'b0, 1'b0, 4'b0100, 3'd2, 1'b0},  // master 2 granted
      '{4'b0000, 1'b0, 1'b0, 4'b0000, 3'd0, 1'b1},  // master 2 drops: pointer stays at 3
      '{4'b1111, 1'b0, 1'b0, 4'b0001, 3'd0, 1'b0},  // search restarts at master 0
      '{4'b1111, 1'b1, 1'b0, 4'b0001, 3'd0, 1'b0},  // begin -> BUSY
      '{4'b0000, 1'b0, 1'b0, 4'b0001, 3'd0, 1'b0},  // request changes ignored in BUSY
      '{4'b1111, 1'b0, 1'b1, 4'b0000, 3'd0, 1'b1},  // end -> IDLE, last = 0
      '{4'b1111, 1'b0, 1'b0, 4'b0010, 3'd1, 1'b0},  // next is master 1
      '{4'b1111, 1'b1, 1'b1, 4'b0010, 3'd1, 1'b0},  // end ignored in GRANTED
      '{4'b1111, 1'b0, 1'b1, 4'b0000, 3'd0, 1'b1},  // end -> last = 1
      '{4'b0000, 1'b1, 1'b1, 4'b0000, 3'd0, 1'b1},  // strobes ignored in IDLE
      '{4'b1001, 1'b0, 1'b0, 4'b1000, 3'd3, 1'b0},  // skip to master 3
      '{4'b1001, 1'b1, 1'b0, 4'b1000, 3'd3, 1'b0},
      '{4'b1001, 1'b0, 1'b1, 4'b0000, 3'd0, 1'b1},  // last = 3
      '{4'b1001, 1'b0, 1'b0, 4'b0001, 3'd0, 1'b0},  // wrap to master 0
      '{4'b0001, 1'b1, 1'b0, 4'b0001, 3'd0, 1'b0},
      '{4'b0001, 1'b0, 1'b1, 4'b0000, 3'd0, 1'b1},  // last = 0
      '{4'b0001, 1'b0, 1'b0, 4'b0001, 3'd0, 1'b0},  // sole requester wins again
      '{4'b0000, 1'b0, 1'b0, 4'b0000, 3'd0, 1'b1}
    };

    // Table-driven vectors
    do_reset();
    for (int v = 0; v < 20; v++) begin
      drive(vecs[v].req, vecs[v].beg, vecs[v].endt);
      push_exp(vecs[v].grant, vecs[v].idx, vecs[v].idle, 1'b0, 1'b0);
      step();
      pop_compare($sformatf("vec%0d", v));
    end

    // Continuous requests, 3-cycle transactions: order 0,1,2,3,0
    do_reset();
    drive(4'b1111, 1'b0, 1'b0);
    for (int t = 0; t < 5; t++) push_exp(4'(1 << (t % 4)), 3'(t % 4), 1'b0, 1'b0, 1'b0);
    for (int t = 0; t < 5; t++) begin
      int waited;
      waited = 0;
      step();
      while (grantsOut == '0 && waited < 6) begin
        step();
        waited++;
      end
      if (grantsOut == '0) begin
        vectorsApplied++;
        miscompares++;
        $display("FAIL rr_grant_wait: got no grant, want grant within 6 cycles");
        break;
      end
      check("rr_latency", 16'(waited), 16'd0);
      pop_compare($sformatf("rr_order%0d", t));
      drive(4'b1111, 1'b1, 1'b0);
      step();
      drive(4'b1111, 1'b0, 1'b0);
      step();
      drive(4'b1111, 1'b0, 1'b1);
      step();
      check("rr_idle_gap", 16'({busIdleOut, grantsOut}), 16'({1'b1, 4'b0000}));
      drive(4'b1111, 1'b0, 1'b0);
    end

    // Asynchronous reset during BUSY
    do_reset();
    drive(4'b0001, 1'b0, 1'b0);
    step();
    drive(4'b0001, 1'b1, 1'b0);
    step();
    check("busy_before_reset", 16'({grantsOut, busIdleOut}), 16'({4'b0001, 1'b0}));
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_outputs", 16'(observed()), 16'({4'b0000, 3'd0, 1'b1, 1'b0, 1'b0}));
    check("async_reset_state", 16'(debugState), 16'(IDLE));
    @(posedge clock);
    #1;
    check("reset_no_strobe", 16'({endTransactionOut, busErrorOut}), 16'd0);
    drive(4'b1111, 1'b0, 1'b0);
    reset = 1'b0;
    step();
    check("after_reset_master0", 16'({grantsOut, grantIndexOut}), 16'({4'b0001, 3'd0}));

`ifdef BUS_ARB_WATCHDOG_EN
    // Watchdog expiry: strobes 10 cycles after the grant
    do_reset();
    drive(4'b0010, 1'b0, 1'b0);
    step();
    check("wd_grant", 16'({grantsOut, grantIndexOut}), 16'({4'b0010, 3'd1}));
    drive(4'b0010, 1'b1, 1'b0);
    step();
    drive(4'b0010, 1'b0, 1'b0);
    for (int k = 2; k <= 9; k++) begin
      step();
      check($sformatf("wd_hold%0d", k), 16'(observed()), 16'({4'b0010, 3'd1, 1'b0, 1'b0, 1'b0}));
    end
    step();
    check("wd_abort", 16'(observed()), 16'({4'b0000, 3'd0, 1'b0, 1'b1, 1'b1}));
    step();
    check("wd_after_abort", 16'(observed()), 16'({4'b0000, 3'd0, 1'b1, 1'b0, 1'b0}));
    drive(4'b1111, 1'b0, 1'b0);
    step();
    check("wd_pointer_advanced", 16'({grantsOut, grantIndexOut}), 16'({4'b0100, 3'd2}));

    // End arriving in the timeout cycle wins
    do_reset();
    drive(4'b0010, 1'b0, 1'b0);
    step();
    drive(4'b0010, 1'b1, 1'b0);
    step();
    drive(4'b0010, 1'b0, 1'b0);
    repeat (8) step();
    drive(4'b0010, 1'b0, 1'b1);
    step();
    check("wd_end_wins", 16'(observed()), 16'({4'b0000, 3'd0, 1'b1, 1'b0, 1'b0}));
    drive(4'b1111, 1'b0, 1'b0);
    step();
    check("wd_end_no_strobe", 16'({endTransactionOut, busErrorOut}), 16'd0);
    check("wd_end_pointer", 16'({grantsOut, grantIndexOut}), 16'({4'b0100, 3'd2}));
`else
    // No watchdog: a long transaction is never aborted
    do_reset();
    drive(4'b0010, 1'b0, 1'b0);
    step();
    drive(4'b0010, 1'b1, 1'b0);
    step();
    drive(4'b0010, 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) begin
      step();
      check($sformatf("nowd_hold%0d", k), 16'(observed()), 16'({4'b0010, 3'd1, 1'b0, 1'b0, 1'b0}));
    end
    drive(4'b0010, 1'b0, 1'b1);
    step();
    check("nowd_end", 16'(observed()), 16'({4'b0000, 3'd0, 1'b1, 1'b0, 1'b0}));
`endif

    // Final report
    check("queue_drained", 16'(exp_q.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule
